// File: rtl/branch_sequencer.sv
// Registered branch sequencer: holds ALU flags, accepts one branch at a time, then
// issues the PC write / flush strobe and, for the link code, a link-register write.
module branch_sequencer #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned FCODE_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flag_we,
  input  logic               i_carry,
  input  logic               i_zero,
  input  logic               i_sign,
  input  logic               i_br_valid,
  output logic               o_br_ready,
  input  logic [FCODE_W-1:0] i_fcode,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [PC_W-1:0]    i_offset,
  input  logic [PC_W-1:0]    i_rs_val,
  input  logic               i_stall,
  output logic               o_pc_we,
  output logic [PC_W-1:0]    o_target,
  output logic               o_flush,
  output logic               o_link_we,
  output logic [PC_W-1:0]    o_link_data,
  output logic               o_taken
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RESOLVE = 2'd1;
  localparam logic [1:0] LINK    = 2'd2;

  localparam logic [FCODE_W-1:0] FC_LINK   = FCODE_W'(6);
  localparam logic [FCODE_W-1:0] FC_REGJMP = FCODE_W'(7);

  logic [1:0]         state_q, state_d;
  logic [2:0]         flags_q;  // {carry, zero, sign}
  logic [2:0]         flags_eff;
  logic [FCODE_W-1:0] fcode_q;
  logic               cond_q;
  logic               taken_q;
  logic [PC_W-1:0]    target_q;
  logic [PC_W-1:0]    link_data_q;
  logic               accept;

  function automatic logic eval_cond(input logic [FCODE_W-1:0] fc, input logic [2:0] fl);
    logic c, z, s;
    {c, z, s} = fl;
    case (fc)
      FCODE_W'(1): eval_cond = c;
      FCODE_W'(2): eval_cond = ~c;
      FCODE_W'(3): eval_cond = z;
      FCODE_W'(4): eval_cond = s;
      FCODE_W'(5): eval_cond = ~z;
      default:     eval_cond = 1'b1;
    endcase
  endfunction

  // Flags written in the accept cycle are forwarded into the resolution. The condition
  // is captured at accept so stalls and later flag writes cannot disturb it.
  assign flags_eff = i_flag_we ? {i_carry, i_zero, i_sign} : flags_q;
  assign accept    = (state_q == IDLE) && i_br_valid && !i_stall;

  always_comb begin
    state_d = state_q;
    if (!i_stall) begin
      case (state_q)
        IDLE:    if (i_br_valid) state_d = RESOLVE;
        RESOLVE: state_d = (cond_q && (fcode_q == FC_LINK)) ? LINK : IDLE;
        LINK:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      flags_q     <= 3'b000;
      fcode_q     <= '0;
      cond_q      <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      link_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (i_flag_we) flags_q <= {i_carry, i_zero, i_sign};
      if (accept) begin
        fcode_q     <= i_fcode;
        cond_q      <= eval_cond(i_fcode, flags_eff);
        target_q    <= (i_fcode == FC_REGJMP) ? i_rs_val : i_pc + i_offset;
        link_data_q <= i_pc + PC_W'(4);
      end
      if ((state_q == RESOLVE) && !i_stall) taken_q <= cond_q;
    end
  end

  always_comb begin
    o_br_ready  = (state_q == IDLE);
    o_pc_we     = (state_q == RESOLVE) && cond_q && !i_stall;
    o_flush     = o_pc_we;
    o_link_we   = (state_q == LINK) && !i_stall;
    o_taken     = (state_q == RESOLVE) ? cond_q : taken_q;
    o_target    = target_q;
    o_link_data = link_data_q;
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios followed by randomized branches,
// each checked against a transaction-level model of flags, conditions and timing.
module tb_branch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        flag_we, carry, zero, sign;
  logic        br_valid, br_ready;
  logic [4:0]  fcode;
  logic [31:0] pc, offset, rs_val;
  logic        stall;
  logic        pc_we, flush, link_we, taken;
  logic [31:0] target, link_data;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: flags as plain bits, plus the last resolved outcome.
  logic mc = 1'b0, mz = 1'b0, ms = 1'b0;
  logic prev_taken = 1'b0;

  branch_sequencer #(.PC_W(32), .FCODE_W(5)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_flag_we  (flag_we),
    .i_carry    (carry),
    .i_zero     (zero),
    .i_sign     (sign),
    .i_br_valid (br_valid),
    .o_br_ready (br_ready),
    .i_fcode    (fcode),
    .i_pc       (pc),
    .i_offset   (offset),
    .i_rs_val   (rs_val),
    .i_stall    (stall),
    .o_pc_we    (pc_we),
    .o_target   (target),
    .o_flush    (flush),
    .o_link_we  (link_we),
    .o_link_data(link_data),
    .o_taken    (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [4:0] fc);
    case (fc)
      5'd1:    return mc;
      5'd2:    return !mc;
      5'd3:    return mz;
      5'd4:    return ms;
      5'd5:    return !mz;
      default: return 1'b1;
    endcase
  endfunction

  // Called just after a rising edge with the sequencer idle.
  task automatic set_flags(input logic [2:0] f);
    flag_we = 1'b1;
    {carry, zero, sign} = f;
    @(posedge clk); #1;
    flag_we = 1'b0;
    {mc, mz, ms} = f;
  endtask

  task automatic do_branch(input logic [4:0] fc, input logic [31:0] a_pc, input logic [31:0] a_off,
                           input logic [31:0] a_rs, input logic fwe, input logic [2:0] f,
                           input int istall, input int rstall, input logic rfwe,
                           input logic [2:0] rf);
    logic        exp_t;
    logic [31:0] exp_tgt, exp_link;
    br_valid = 1'b1;
    fcode = fc; pc = a_pc; offset = a_off; rs_val = a_rs;
    flag_we = fwe; {carry, zero, sign} = f;
    stall = 1'b1;
    for (int k = 0; k < istall; k++) begin
      @(negedge clk);
      check("idle_stall_ready", 32'(br_ready), 32'd1);
      check("idle_stall_strobes", 32'({pc_we, flush, link_we}), 32'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(br_ready), 32'd1);
    check("held_taken", 32'(taken), 32'(prev_taken));
    check("idle_strobes", 32'({pc_we, flush, link_we}), 32'd0);
    if (fwe) {mc, mz, ms} = f;
    exp_t    = ref_taken(fc);
    exp_tgt  = (fc == 5'd7) ? a_rs : a_pc + a_off;
    exp_link = a_pc + 32'd4;
    @(posedge clk); #1;
    br_valid = 1'b0; flag_we = 1'b0;
    fcode = 5'($urandom); pc = $urandom; offset = $urandom; rs_val = $urandom;
    stall = (rstall > 0);
    for (int k = 0; k < rstall; k++) begin
      @(negedge clk);
      check("res_stall_strobes", 32'({pc_we, flush, link_we}), 32'd0);
      check("res_stall_ready", 32'(br_ready), 32'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    flag_we = rfwe; {carry, zero, sign} = rf;
    @(negedge clk);
    check("res_pc_we", 32'(pc_we), 32'(exp_t));
    check("res_flush", 32'(flush), 32'(exp_t));
    check("res_taken", 32'(taken), 32'(exp_t));
    check("res_ready", 32'(br_ready), 32'd0);
    check("res_link_we", 32'(link_we), 32'd0);
    if (exp_t) check("res_target", target, exp_tgt);
    @(posedge clk); #1;
    flag_we = 1'b0;
    if (rfwe) {mc, mz, ms} = rf;
    prev_taken = exp_t;
    if (exp_t && fc == 5'd6) begin
      @(negedge clk);
      check("link_we", 32'(link_we), 32'd1);
      check("link_data", link_data, exp_link);
      check("link_pc_we", 32'(pc_we), 32'd0);
      check("link_ready", 32'(br_ready), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [4:0] rfc;
    rst_n = 1'b0;
    flag_we = 0; carry = 0; zero = 0; sign = 0;
    br_valid = 0; fcode = 0; pc = 0; offset = 0; rs_val = 0; stall = 0;
    #3;
    check("rst_ready", 32'(br_ready), 32'd1);
    check("rst_strobes", 32'({pc_we, flush, link_we}), 32'd0);
    check("rst_taken", 32'(taken), 32'd0);
    check("rst_target", target, 32'd0);
    check("rst_link_data", link_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry condition taken
    set_flags(3'b100);
    do_branch(5'd1, 32'h100, 32'h20, 32'h0, 1'b0, 3'b000, 0, 0, 1'b0, 3'b000);
    // Forwarded zero=0 makes "not zero" taken, forwarded zero=1 makes it not taken
    set_flags(3'b010);
    do_branch(5'd5, 32'h300, 32'h40, 32'h0, 1'b1, 3'b000, 0, 0, 1'b0, 3'b000);
    set_flags(3'b000);
    do_branch(5'd5, 32'h300, 32'h40, 32'h0, 1'b1, 3'b010, 0, 0, 1'b0, 3'b000);
    // Link with negative offset, back-to-back into register jump and wrapping target
    do_branch(5'd6, 32'h200, 32'hFFFF_FFF0, 32'h0, 1'b0, 3'b000, 0, 0, 1'b0, 3'b000);
    do_branch(5'd7, 32'h400, 32'h10, 32'hDEAD_0000, 1'b0, 3'b000, 0, 0, 1'b0, 3'b000);
    do_branch(5'd0, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 3'b000, 0, 0, 1'b0, 3'b000);
    // Stall in RESOLVE, stall in IDLE, flag write in RESOLVE does not affect result
    do_branch(5'd0, 32'h500, 32'h4, 32'h0, 1'b0, 3'b000, 0, 3, 1'b0, 3'b000);
    do_branch(5'd2, 32'h600, 32'h8, 32'h0, 1'b1, 3'b100, 2, 0, 1'b1, 3'b000);
    do_branch(5'd3, 32'h700, 32'hC, 32'h0, 1'b1, 3'b010, 0, 1, 1'b1, 3'b000);

    // Asynchronous reset during RESOLVE
    br_valid = 1'b1; fcode = 5'd0; pc = 32'h800; offset = 32'h10;
    @(posedge clk); #1;
    br_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({pc_we, flush, link_we}), 32'd0);
    check("mid_rst_ready", 32'(br_ready), 32'd1);
    check("mid_rst_target", target, 32'd0);
    check("mid_rst_taken", 32'(taken), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    {mc, mz, ms} = 3'b000;
    prev_taken = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(br_ready), 32'd1);
    check("post_rst_pc_we", 32'(pc_we), 32'd0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) set_flags(3'($urandom));
      rfc = 5'($urandom_range(0, 11));
      if (rfc > 5'd9) rfc = 5'($urandom_range(10, 31));
      do_branch(rfc, $urandom, $urandom, $urandom, 1'($urandom), 3'($urandom),
                ($urandom_range(0, 3) == 0) ? 1 : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                1'($urandom), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
